// File: rtl/axi_rdma_pkg.sv
// Shared definitions for the AXI read/write DMA engines.
//   rdma_state_t : command sequencer states
//   ARSIZE_4B    : AxSIZE for 32-bit beats
//   BURST_INCR   : AxBURST incrementing burst
//   PAGE_BYTES / PAGE_DWORDS : AXI 4 KB boundary that no burst may cross
package axi_rdma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CALC,
      S_ASTRB,
      S_RSTRB,
      S_INCR
   } rdma_state_t;

   localparam logic [2:0]  ARSIZE_4B   = 3'b010;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam int unsigned PAGE_BYTES  = 4096;
   localparam int unsigned PAGE_DWORDS = PAGE_BYTES / 4;

endpackage

// File: rtl/axi_rdma_if.sv
// Bundle of the read-DMA command, AXI AR/R and output-stream signals.
//   master : the DMA engine (accepts commands, drives AR, sinks R, sources stream)
//   slave  : the environment (issues commands, AXI memory, stream consumer)
interface axi_rdma_if #(
   parameter int ADDRESS_BITS = 32,
   parameter int LENGTH_BITS  = 32
);
   logic [ADDRESS_BITS-1:0] cmd_address;
   logic [LENGTH_BITS-1:0]  cmd_bytes;
   logic                    cmd_valid;
   logic                    cmd_ready;

   logic [3:0]              axi_m_arid;
   logic [ADDRESS_BITS-1:0] axi_m_araddr;
   logic [7:0]              axi_m_arlen;
   logic [2:0]              axi_m_arsize;
   logic [1:0]              axi_m_arburst;
   logic                    axi_m_arvalid;
   logic                    axi_m_arready;

   logic [3:0]              axi_m_rid;
   logic [31:0]             axi_m_rdata;
   logic [1:0]              axi_m_rresp;
   logic                    axi_m_rlast;
   logic                    axi_m_rvalid;
   logic                    axi_m_rready;

   logic [31:0]             dout_tdata;
   logic [3:0]              dout_tkeep;
   logic                    dout_tlast;
   logic                    dout_tvalid;
   logic                    dout_tready;

   logic                    rd_error;

   modport master (
      input  cmd_address, cmd_bytes, cmd_valid,
      output cmd_ready,
      output axi_m_arid, axi_m_araddr, axi_m_arlen, axi_m_arsize, axi_m_arburst, axi_m_arvalid,
      input  axi_m_arready,
      input  axi_m_rid, axi_m_rdata, axi_m_rresp, axi_m_rlast, axi_m_rvalid,
      output axi_m_rready,
      output dout_tdata, dout_tkeep, dout_tlast, dout_tvalid,
      input  dout_tready,
      output rd_error
   );

   modport slave (
      output cmd_address, cmd_bytes, cmd_valid,
      input  cmd_ready,
      input  axi_m_arid, axi_m_araddr, axi_m_arlen, axi_m_arsize, axi_m_arburst, axi_m_arvalid,
      output axi_m_arready,
      output axi_m_rid, axi_m_rdata, axi_m_rresp, axi_m_rlast, axi_m_rvalid,
      input  axi_m_rready,
      input  dout_tdata, dout_tkeep, dout_tlast, dout_tvalid,
      output dout_tready,
      input  rd_error
   );

endinterface

// File: rtl/axi_rdma_keep.sv
// Byte-enable generator for one stream beat.
//   i_offset     : byte lane of the first valid byte of the command
//   i_end_offset : (offset + bytes) mod 4; 0 means the last dword is full
//   i_first      : beat is the first of the command
//   i_last       : beat is the last of the command
//   o_keep       : tkeep; lowest-address lane maps to bit 3 when big-endian, bit 0 otherwise
module axi_rdma_keep #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0] i_offset,
   input  logic [1:0] i_end_offset,
   input  logic       i_first,
   input  logic       i_last,
   output logic [3:0] o_keep
);

   logic [3:0] w_lanes;

   // w_lanes is indexed by address lane (lane 0 = lowest byte address)
   always_comb begin
      w_lanes = '1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i_first && (i < {30'd0, i_offset}))
            w_lanes[i] = 1'b0;
         if (i_last && (i_end_offset != 2'd0) && (i >= {30'd0, i_end_offset}))
            w_lanes[i] = 1'b0;
      end
   end

   always_comb begin
      o_keep = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (BIG_ENDIAN) o_keep[3-i] = w_lanes[i];
         else            o_keep[i]   = w_lanes[i];
      end
   end

endmodule

// File: rtl/axi_rdma.sv
// AXI4 read DMA: turns a (byte address, byte count) command into 4 KB-safe
// INCR bursts of 32-bit beats and forwards the read data unbuffered onto a
// 32-bit stream with byte-accurate tkeep and a tlast on the final beat.
//   aclk, areset : clock, asynchronous active-high reset
//   bus (master) : command, AXI AR/R channels, output stream, sticky rd_error
module axi_rdma
   import axi_rdma_pkg::*;
#(
   parameter int    ADDRESS_BITS   = 32,
   parameter int    LENGTH_BITS    = 32,
   parameter int    MAX_BURST      = 256,
   parameter string MEM_BIG_ENDIAN = "TRUE"
) (
   input  logic        aclk,
   input  logic        areset,
   axi_rdma_if.master  bus
);

   localparam bit LP_BIG_ENDIAN = (MEM_BIG_ENDIAN == "TRUE");

   rdma_state_t             r_state, w_next;
   logic [ADDRESS_BITS-1:0] r_addr;
   logic [1:0]              r_offset;
   logic [LENGTH_BITS-1:0]  r_bytes;
   logic [LENGTH_BITS-1:0]  r_remaining;
   logic [8:0]              r_fetch;
   logic [7:0]              r_arlen;
   logic [8:0]              r_beat;
   logic                    r_first;
   logic                    r_error;

   logic [LENGTH_BITS:0]    w_sum;
   logic [LENGTH_BITS-1:0]  w_total;
   logic [10:0]             w_to_page;
   logic [10:0]             w_cap;
   logic [8:0]              w_fetch;
   logic                    w_beat_last;
   logic                    w_cmd_last;
   logic                    w_rbeat;
   logic [1:0]              w_end_offset;
   logic [3:0]              w_keep;
   logic                    w_unused;

   // one extra bit keeps the carry of bytes + offset + 3 before the divide by 4
   assign w_sum   = (LENGTH_BITS+1)'(r_bytes) + (LENGTH_BITS+1)'(r_offset) + (LENGTH_BITS+1)'(3);
   assign w_total = (r_bytes == '0) ? '0 : LENGTH_BITS'(w_sum[LENGTH_BITS:2]);

   assign w_to_page    = 11'(PAGE_DWORDS) - {1'b0, r_addr[11:2]};
   assign w_cap        = (11'(MAX_BURST) < w_to_page) ? 11'(MAX_BURST) : w_to_page;
   assign w_fetch      = (r_remaining < LENGTH_BITS'(w_cap)) ? r_remaining[8:0] : w_cap[8:0];
   assign w_beat_last  = (r_beat == r_fetch - 9'd1);
   assign w_cmd_last   = w_beat_last && (r_remaining == LENGTH_BITS'(r_fetch));
   assign w_rbeat      = (r_state == S_RSTRB) && bus.axi_m_rvalid && bus.dout_tready;
   assign w_end_offset = r_offset + r_bytes[1:0];
   assign w_unused     = ^{bus.axi_m_rid, w_sum[1:0]};

   axi_rdma_keep #(.BIG_ENDIAN(LP_BIG_ENDIAN)) u_keep (
      .i_offset     (r_offset),
      .i_end_offset (w_end_offset),
      .i_first      (r_first),
      .i_last       (w_cmd_last),
      .o_keep       (w_keep)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.cmd_valid) w_next = S_INIT;
         S_INIT:  w_next = (w_total == '0) ? S_IDLE : S_CALC;
         S_CALC:  w_next = S_ASTRB;
         S_ASTRB: if (bus.axi_m_arready) w_next = S_RSTRB;
         S_RSTRB: if (w_rbeat && w_beat_last) w_next = S_INCR;
         S_INCR:  w_next = (r_remaining != LENGTH_BITS'(r_fetch)) ? S_CALC : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready     = (r_state == S_IDLE);
      bus.axi_m_arid    = '0;
      bus.axi_m_araddr  = r_addr;
      bus.axi_m_arlen   = r_arlen;
      bus.axi_m_arsize  = ARSIZE_4B;
      bus.axi_m_arburst = BURST_INCR;
      bus.axi_m_arvalid = (r_state == S_ASTRB);
      bus.axi_m_rready  = (r_state == S_RSTRB) && bus.dout_tready;
      bus.dout_tvalid   = (r_state == S_RSTRB) && bus.axi_m_rvalid;
      bus.dout_tdata    = bus.axi_m_rdata;
      bus.dout_tkeep    = w_keep;
      bus.dout_tlast    = (r_state == S_RSTRB) && w_cmd_last;
      bus.rd_error      = r_error;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_addr      <= '0;
         r_offset    <= '0;
         r_bytes     <= '0;
         r_remaining <= '0;
         r_fetch     <= '0;
         r_arlen     <= '0;
         r_beat      <= '0;
         r_first     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.cmd_valid) begin
               r_addr   <= {bus.cmd_address[ADDRESS_BITS-1:2], 2'b00};
               r_offset <= bus.cmd_address[1:0];
               r_bytes  <= bus.cmd_bytes;
               r_error  <= 1'b0;
               r_first  <= 1'b1;
            end
            S_INIT: r_remaining <= w_total;
            S_CALC: begin
               r_fetch <= w_fetch;
               r_arlen <= 8'(w_fetch - 9'd1);
               r_beat  <= '0;
            end
            S_RSTRB: if (w_rbeat) begin
               r_beat  <= r_beat + 9'd1;
               r_first <= 1'b0;
               // rlast is only cross-checked; the local beat count drives sequencing
               if ((bus.axi_m_rresp != 2'b00) || (bus.axi_m_rlast != w_beat_last))
                  r_error <= 1'b1;
            end
            S_INCR: begin
               r_addr      <= r_addr + ADDRESS_BITS'({r_fetch, 2'b00});
               r_remaining <= r_remaining - LENGTH_BITS'(r_fetch);
            end
            default: ;
         endcase
      end
   end

endmodule
